dac_conv_sequencer: RTL

- Sequences one DAC conversion from a configuration set loaded by the serial configuration front-end: vref (4 b), data (8 b), conver (8 b), comp (6 b).
- Drives the 3-bit switch-control buses VR, VM and VRC through the phases precharge, settle, bit drive and hold.
- Sits between the serial configuration loaders and the analog switch array, and reports busy/done to the top level.

---
 rtl/dac_conv_sequencer_pkg.sv | 28 ++
 rtl/dac_conv_sequencer_if.sv | 33 +++
 rtl/dac_conv_sequencer_counter.sv | 26 ++
 rtl/dac_conv_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dac_conv_sequencer_pkg.sv
// Shared types and constants for the DAC conversion sequencer: FSM states,
// switch-control codes and default widths.
package dac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRECHARGE,
        SETTLE,
        BIT,
        HOLD,
        DONE
    } state_t;

    localparam logic [2:0] VM_FLOAT  = 3'b000;
    localparam logic [2:0] VM_VREF   = 3'b001;
    localparam logic [2:0] VM_GND    = 3'b010;
    localparam logic [2:0] VM_HOLD   = 3'b100;
    localparam logic [2:0] VRC_RESET = 3'b111;

    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned SETTLE_W_DEF = 6;
    localparam int unsigned HOLD_W_DEF   = 8;

    function automatic logic [2:0] vm_code(input logic b);
        return b ? VM_VREF : VM_GND;
    endfunction

endpackage

// File: rtl/dac_conv_sequencer_if.sv
// Configuration handshake and switch-control bus between the config
// front-end (master) and the sequencer (slave).
interface dac_conv_sequencer_if
    import dac_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned SETTLE_W = SETTLE_W_DEF,
    parameter int unsigned HOLD_W   = HOLD_W_DEF
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [3:0]          vref;
    logic [DATA_W-1:0]   data;
    logic [HOLD_W-1:0]   conver;
    logic [SETTLE_W-1:0] comp;
    logic                abort;
    logic [2:0]          VR;
    logic [2:0]          VM;
    logic [2:0]          VRC;
    logic [2:0]          bit_idx;
    logic                busy;
    logic                done;

    modport master (
        output cfg_valid, vref, data, conver, comp, abort,
        input  cfg_ready, VR, VM, VRC, bit_idx, busy, done
    );

    modport slave (
        input  cfg_valid, vref, data, conver, comp, abort,
        output cfg_ready, VR, VM, VRC, bit_idx, busy, done
    );
endinterface

// File: rtl/dac_conv_sequencer_counter.sv
// Loadable down-counter shared by the SETTLE and HOLD phases; o_expired
// flags the final cycle of the loaded count.
module dac_cycle_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_en,
    output logic             o_expired
);
    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_expired = (r_cnt == WIDTH'(1));
endmodule

// File: rtl/dac_conv_sequencer.sv
// DAC conversion sequencer: precharge, settle, bit drive and hold phases.
// Define DAC_LSB_FIRST_EN to drive bits LSB first instead of MSB first.
module dac_conv_sequencer
    import dac_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned SETTLE_W = SETTLE_W_DEF,
    parameter int unsigned HOLD_W   = HOLD_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    dac_conv_sequencer_if.slave  bus
);
`ifdef DAC_LSB_FIRST_EN
    localparam logic [2:0] IDX_FIRST = 3'd0;
    localparam logic [2:0] IDX_LAST  = 3'(DATA_W - 1);
    localparam bit         LSB_FIRST = 1'b1;
`else
    localparam logic [2:0] IDX_FIRST = 3'(DATA_W - 1);
    localparam logic [2:0] IDX_LAST  = 3'd0;
    localparam bit         LSB_FIRST = 1'b0;
`endif

    state_t              r_state;
    logic [3:0]          r_vref;
    logic [DATA_W-1:0]   r_data;
    logic [HOLD_W-1:0]   r_conver;
    logic [SETTLE_W-1:0] r_comp;
    logic [2:0]          r_vr, r_vm, r_vrc, r_bit_idx;
    logic                r_busy, r_done, r_cfg_ready;

    logic                w_load, w_cnt_en, w_expired, w_last_bit, w_abort;
    logic [HOLD_W-1:0]   w_load_val;
    logic [2:0]          w_next_idx, w_next_vm;

    always_comb begin
        w_last_bit = (r_bit_idx == IDX_LAST);
        w_load     = ((r_state == PRECHARGE) && (r_comp != '0)) ||
                     ((r_state == BIT) && w_last_bit && (r_conver != '0));
        w_load_val = (r_state == PRECHARGE) ? HOLD_W'(r_comp) : r_conver;
        w_cnt_en   = (r_state == SETTLE) || (r_state == HOLD);
        w_abort    = bus.abort && (r_state inside {PRECHARGE, SETTLE, BIT, HOLD});
        // Entering BIT starts at IDX_FIRST; inside BIT step towards IDX_LAST
        if (r_state == BIT) begin
            w_next_idx = LSB_FIRST ? (r_bit_idx + 3'd1) : (r_bit_idx - 3'd1);
        end else begin
            w_next_idx = IDX_FIRST;
        end
        w_next_vm = vm_code(r_data[w_next_idx] ^ r_vref[3]);
    end

    dac_cycle_counter #(.WIDTH(HOLD_W)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_value   (w_load_val),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_vref      <= '0;
            r_data      <= '0;
            r_conver    <= '0;
            r_comp      <= '0;
            r_vr        <= '0;
            r_vm        <= '0;
            r_vrc       <= '0;
            r_bit_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else if (w_abort) begin
            r_state     <= IDLE;
            r_vr        <= '0;
            r_vm        <= '0;
            r_vrc       <= '0;
            r_bit_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        r_vref      <= bus.vref;
                        r_data      <= bus.data;
                        r_conver    <= bus.conver;
                        r_comp      <= bus.comp;
                        r_state     <= PRECHARGE;
                        r_vrc       <= VRC_RESET;
                        r_busy      <= 1'b1;
                        r_cfg_ready <= 1'b0;
                    end
                end
                PRECHARGE, SETTLE: begin
                    if ((r_state == PRECHARGE) && (r_comp != '0)) begin
                        r_state <= SETTLE;
                        r_vrc   <= '0;
                    end else if ((r_state == PRECHARGE) || w_expired) begin
                        r_state   <= BIT;
                        r_vr      <= w_next_idx;
                        r_vm      <= w_next_vm;
                        r_vrc     <= r_vref[2:0];
                        r_bit_idx <= w_next_idx;
                    end
                end
                BIT: begin
                    if (!w_last_bit) begin
                        r_vr      <= w_next_idx;
                        r_vm      <= w_next_vm;
                        r_bit_idx <= w_next_idx;
                    end else if (r_conver != '0) begin
                        r_state   <= HOLD;
                        r_vr      <= '0;
                        r_vm      <= VM_HOLD;
                        r_bit_idx <= '0;
                    end else begin
                        r_state   <= DONE;
                        r_vr      <= '0;
                        r_vm      <= VM_FLOAT;
                        r_vrc     <= '0;
                        r_bit_idx <= '0;
                        r_done    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_expired) begin
                        r_state <= DONE;
                        r_vm    <= VM_FLOAT;
                        r_vrc   <= '0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.VR        = r_vr;
    assign bus.VM        = r_vm;
    assign bus.VRC       = r_vrc;
    assign bus.bit_idx   = r_bit_idx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.cfg_ready = r_cfg_ready;
endmodule
